// File: rtl/stereo_frame_capture_pkg.sv
// rtl/stereo_frame_capture_pkg.sv - shared geometry constants and capture state encoding
package stereo_frame_capture_pkg;

  localparam int SCALE        = 16;
  localparam int WIDTH        = 46;
  localparam int HEIGHT       = 30;
  localparam int LOG2_SCALE   = $clog2(SCALE);
  localparam int FRAME_PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_W       = $clog2(FRAME_PIXELS);
  localparam int X_W          = 11;
  localparam int Y_W          = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_L = 3'd1,
    ST_CAP_L  = 3'd2,
    ST_WAIT_R = 3'd3,
    ST_CAP_R  = 3'd4,
    ST_READY  = 3'd5
  } cap_state_t;

endpackage

// File: rtl/stereo_frame_capture_frame_ram.sv
// rtl/stereo_frame_capture_frame_ram.sv - two-bank frame store, one write port, one registered read port
module stereo_frame_capture_frame_ram
  import stereo_frame_capture_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] bank0 [FRAME_PIXELS];
  logic [7:0] bank1 [FRAME_PIXELS];

  // Array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) bank1[wr_addr] <= wr_data;
      else         bank0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else if (rd_en) begin
      rd_data <= rd_bank ? bank1[rd_addr] : bank0[rd_addr];
    end
  end

endmodule

// File: rtl/stereo_frame_capture.sv
// rtl/stereo_frame_capture.sv - decimating left/right frame capture with raster read-out
module stereo_frame_capture
  import stereo_frame_capture_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       capture,
  input  logic [7:0] cam_pixel,
  input  logic       cam_valid,
  input  logic       cam_href,
  input  logic       cam_vref,
  output logic       cam_sel,
  input  logic       image_sel,
  input  logic       rd_en,
  output logic [7:0] image_data,
  output logic       buffer_ready,
  output logic       busy
);

  localparam logic [X_W-1:0]    X_LIMIT   = X_W'(WIDTH * SCALE);
  localparam logic [Y_W-1:0]    Y_LIMIT   = Y_W'(HEIGHT * SCALE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] WIDTH_A   = ADDR_W'(WIDTH);

  cap_state_t state, state_nxt;

  logic              vref_d, href_d, sel_d;
  logic              vref_rise, vref_fall, href_fall;
  logic              capturing, waiting, in_grid;
  logic              wr_en, wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [X_W-1:0]    x_cnt;
  logic [Y_W-1:0]    y_cnt;
  logic [ADDR_W-1:0] rd_ptr, rd_addr;
  logic              rd_req, sel_change;

  assign vref_rise = cam_vref & ~vref_d;
  assign vref_fall = ~cam_vref & vref_d;
  assign href_fall = ~cam_href & href_d;
  assign capturing = (state == ST_CAP_L) || (state == ST_CAP_R);
  assign waiting   = (state == ST_WAIT_L) || (state == ST_WAIT_R);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_READY: if (capture)   state_nxt = ST_WAIT_L;
      ST_WAIT_L:         if (vref_fall) state_nxt = ST_CAP_L;
      ST_CAP_L:          if (vref_rise) state_nxt = ST_WAIT_R;
      ST_WAIT_R:         if (vref_fall) state_nxt = ST_CAP_R;
      ST_CAP_R:          if (vref_rise) state_nxt = ST_READY;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs trail the state by one cycle; cam_sel switches with the transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      buffer_ready <= 1'b0;
      cam_sel      <= 1'b0;
    end else begin
      state        <= state_nxt;
      busy         <= capturing || waiting;
      buffer_ready <= (state == ST_READY);
      cam_sel      <= (state_nxt == ST_WAIT_R) || (state_nxt == ST_CAP_R);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vref_d <= 1'b0;
      href_d <= 1'b0;
      sel_d  <= 1'b0;
      x_cnt  <= '0;
      y_cnt  <= '0;
    end else begin
      vref_d <= cam_vref;
      href_d <= cam_href;
      sel_d  <= image_sel;
      if (waiting) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (capturing) begin
        if (href_fall) begin
          x_cnt <= '0;
          if (y_cnt != '1) y_cnt <= y_cnt + 1'b1;
        end else if (cam_valid && cam_href && (x_cnt != '1)) begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
    end
  end

  // Keep only the first pixel of every SCALE x SCALE block that lands inside the grid.
  assign in_grid = (x_cnt[LOG2_SCALE-1:0] == '0) && (y_cnt[LOG2_SCALE-1:0] == '0) &&
                   (x_cnt < X_LIMIT) && (y_cnt < Y_LIMIT);
  assign wr_en   = capturing && cam_valid && cam_href && in_grid;
  assign wr_bank = (state == ST_CAP_R);
  assign wr_addr = ADDR_W'(y_cnt >> LOG2_SCALE) * WIDTH_A + ADDR_W'(x_cnt >> LOG2_SCALE);

  assign sel_change = (image_sel != sel_d);
  assign rd_req     = (state == ST_READY) && rd_en;
  assign rd_addr    = sel_change ? '0 : rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if ((state != ST_READY) || sel_change) begin
      rd_ptr <= '0;
    end else if (rd_en) begin
      rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
    end
  end

  stereo_frame_capture_frame_ram u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (cam_pixel),
    .rd_en   (rd_req),
    .rd_bank (image_sel),
    .rd_addr (rd_addr),
    .rd_data (image_data)
  );

endmodule

// File: tb/tb_stereo_frame_capture.sv
// tb/tb_stereo_frame_capture.sv - randomized self-checking bench against a frame-level memory model
module tb_stereo_frame_capture;
  import stereo_frame_capture_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       capture;
  logic [7:0] cam_pixel;
  logic       cam_valid;
  logic       cam_href;
  logic       cam_vref;
  logic       cam_sel;
  logic       image_sel;
  logic       rd_en;
  logic [7:0] image_data;
  logic       buffer_ready;
  logic       busy;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_mem [2][FRAME_PIXELS];
  logic [7:0] got_mem [2][FRAME_PIXELS];
  logic [7:0] last_exp;
  logic [7:0] pix720;

  stereo_frame_capture dut (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .cam_pixel    (cam_pixel),
    .cam_valid    (cam_valid),
    .cam_href     (cam_href),
    .cam_vref     (cam_vref),
    .cam_sel      (cam_sel),
    .image_sel    (image_sel),
    .rd_en        (rd_en),
    .image_data   (image_data),
    .buffer_ready (buffer_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One camera line; the model stores pixels at the top-left of each in-grid block.
  task automatic send_line(input int bank, input int ln, input int npix, input int mode, input bit gaps);
    logic [7:0] val;
    for (int px = 0; px < npix; px++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          cam_href = 1'b1; cam_valid = 1'b0; @(negedge clk);
        end
      end
      if (mode == 0) val = 8'((px / SCALE) + (ln / SCALE)) ^ ((bank != 0) ? 8'h80 : 8'h00);
      else           val = 8'($urandom_range(255));
      if (px == 720) pix720 = val;
      if ((ln % SCALE == 0) && (ln / SCALE < HEIGHT) && (px % SCALE == 0) && (px / SCALE < WIDTH))
        exp_mem[bank][(ln / SCALE) * WIDTH + px / SCALE] = val;
      cam_href = 1'b1; cam_valid = 1'b1; cam_pixel = val;
      @(negedge clk);
    end
    cam_href = 1'b0; cam_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int bank, input int nlines, input int len, input int mode, input bit gaps);
    for (int ln = 0; ln < nlines; ln++) begin
      if (ln % SCALE == 0) send_line(bank, ln, len, mode, gaps);
      else                 send_line(bank, ln, 1, 1, 1'b0);
    end
  endtask

  task automatic vsync();
    cam_vref = 1'b1; repeat (4) @(negedge clk);
    cam_vref = 1'b0; repeat (3) @(negedge clk);
  endtask

  task automatic vend();
    cam_vref = 1'b1; repeat (4) @(negedge clk);
    cam_vref = 1'b0; repeat (2) @(negedge clk);
  endtask

  task automatic pulse_capture();
    capture = 1'b1; @(negedge clk);
    capture = 1'b0; @(negedge clk);
  endtask

  task automatic read_all(input int bank, input int n);
    int a;
    image_sel = bank[0]; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      a = i % FRAME_PIXELS;
      check($sformatf("rd b%0d a%0d", bank, a), image_data, exp_mem[bank][a]);
      if (i < FRAME_PIXELS) got_mem[bank][a] = image_data;
      last_exp = exp_mem[bank][a];
    end
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; capture = 1'b0; cam_pixel = 8'h00; cam_valid = 1'b0;
    cam_href = 1'b0; cam_vref = 1'b0; image_sel = 1'b0; rd_en = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < FRAME_PIXELS; a++) exp_mem[b][a] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst image_data", image_data, 0);
    check("rst buffer_ready", buffer_ready, 0);
    check("rst busy", busy, 0);
    check("rst cam_sel", cam_sel, 0);
    reset = 1'b0;
    @(negedge clk);

    // Full-size left/right capture with the gradient pattern.
    pulse_capture();
    check("c1 busy", busy, 1);
    check("c1 cam_sel left", cam_sel, 0);
    vsync();
    send_frame(0, 480, 736, 0, 1'b0);
    vsync();
    check("c1 cam_sel right", cam_sel, 1);
    check("c1 not ready", buffer_ready, 0);
    send_frame(1, 480, 736, 0, 1'b0);
    vend();
    check("c1 ready", buffer_ready, 1);
    check("c1 busy done", busy, 0);
    check("c1 cam_sel back", cam_sel, 0);
    read_all(0, FRAME_PIXELS + 1);
    read_all(1, FRAME_PIXELS);
    check("left addr47", got_mem[0][47], 8'h02);
    check("right addr47", got_mem[1][47], 8'h82);

    // Switching bank mid-stream restarts at address 0 of the new bank.
    image_sel = 1'b0; @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1; @(negedge clk);
      check("pre toggle", image_data, exp_mem[0][i]);
    end
    image_sel = 1'b1; rd_en = 1'b1; @(negedge clk);
    @(negedge clk);
    check("toggle addr0", image_data, exp_mem[1][0]);
    @(negedge clk);
    check("toggle addr1", image_data, exp_mem[1][1]);
    last_exp = exp_mem[1][1];
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("hold no rd_en", image_data, last_exp);

    // Overlong line: columns past the grid must not wrap into the next row.
    pulse_capture();
    vsync();
    send_line(0, 0, 800, 1, 1'b1);
    vsync();
    send_frame(1, 17, 60, 1, 1'b1);
    vend();
    check("c2 ready", buffer_ready, 1);
    read_all(1, FRAME_PIXELS);
    read_all(0, FRAME_PIXELS);
    check("addr45 x720", got_mem[0][45], pix720);
    check("addr46 untouched", got_mem[0][46], 8'h01);

    // Capture restart from READY; reads in WAIT_L are ignored.
    pulse_capture();
    check("c3 ready dropped", buffer_ready, 0);
    check("c3 cam_sel", cam_sel, 0);
    rd_en = 1'b1; repeat (4) @(negedge clk); rd_en = 1'b0;
    check("wait_l rd ignored", image_data, last_exp);
    vsync();
    send_line(0, 0, 40, 1, 1'b1);
    pulse_capture();
    send_frame(0, 17, 40, 1, 1'b1);
    vsync();
    check("capture ignored in cap_l", cam_sel, 1);
    send_line(1, 0, 30, 1, 1'b1);
    reset = 1'b1; #1;
    check("mid reset ready", buffer_ready, 0);
    check("mid reset busy", busy, 0);
    check("mid reset cam_sel", cam_sel, 0);
    @(negedge clk); reset = 1'b0;
    vsync(); vend();
    check("idle no ready", buffer_ready, 0);
    check("idle no busy", busy, 0);

    // Fresh capture after reset; untouched cells keep older contents.
    pulse_capture();
    vsync();
    send_frame(0, 33, 100, 1, 1'b1);
    vsync();
    send_frame(1, 17, 60, 1, 1'b1);
    vend();
    check("c4 ready", buffer_ready, 1);
    read_all(0, FRAME_PIXELS);
    read_all(1, FRAME_PIXELS);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stereo_frame_capture.md
# stereo_frame_capture

Capture-side producer for the disparity engine. Takes the raw 8-bit camera pixel stream (href/vref framing), decimates it by SCALE in both axes to a WIDTH×HEIGHT grid, and stores one left and one right frame in internal memory. Once both frames are captured, it asserts buffer_ready and streams bytes to the disparity block in raster order, one per read strobe, from the frame selected by image_sel.

## Interface
- SCALE, 16: decimation factor per axis; must be a power of two.
- WIDTH, 46: stored columns per frame.
- HEIGHT, 30: stored rows per frame.
- clk  in  1  single clock for camera and read sides; camera inputs are pre-synchronised to clk.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- capture  in  1  one-cycle pulse that starts a new left+right capture.
- cam_pixel  in  8  camera luma byte.
- cam_valid  in  1  cam_pixel is valid this cycle.
- cam_href  in  1  high during an active line.
- cam_vref  in  1  high during vertical sync.
- cam_sel  out  1  camera mux select: 0 = left, 1 = right.
- image_sel  in  1  frame the consumer is reading: 0 = left, 1 = right.
- rd_en  in  1  consumer read strobe.
- image_data  out  8  registered read byte.
- buffer_ready  out  1  both frames are valid and readable.
- busy  out  1  a capture is in progress.

## Operation
- States: IDLE, WAIT_L, CAP_L, WAIT_R, CAP_R, READY.
- IDLE: capture → WAIT_L, with cam_sel=0.
- READY: capture → WAIT_L.
- WAIT_x: wait for a falling edge of cam_vref, then go to CAP_x. Clear the x/y counters.
- CAP_x, counters:
  - x counts valid pixels while cam_href=1. x clears on the falling edge of cam_href.
  - y increments on each falling edge of cam_href.
- CAP_x, write rule: write when cam_valid & cam_href & x[log2 SCALE-1:0]==0 & y[log2 SCALE-1:0]==0 & x/SCALE<WIDTH & y/SCALE<HEIGHT.
  - Write address = (y/SCALE)*WIDTH + x/SCALE, into bank x.
- Out-of-grid pixels are ignored.
- CAP_x ends on a rising edge of cam_vref:
  - CAP_L → WAIT_R, and cam_sel becomes 1.
  - CAP_R → READY, and cam_sel returns to 0.
- Grid cells not written in a short frame keep their previous contents.
- Read side: active only in READY.
  - rd_ptr holds 0..WIDTH*HEIGHT-1. rd_en increments it, wrapping from WIDTH*HEIGHT-1 to 0.
  - A change of image_sel (detected against the registered previous value) forces rd_ptr to 0. That takes priority over rd_en in the same cycle.
  - rd_en outside READY is ignored.
- capture is ignored while busy=1.
- Counter widths: x is 11 bits and saturates at 2047; y is 10 bits and saturates at 1023. The address is ceil(log2(WIDTH*HEIGHT)) bits, 11 bits at the defaults.

## Timing
- Reset values:
  - State = IDLE.
  - cam_sel=0, image_data=0, buffer_ready=0, busy=0.
  - rd_ptr=0 and all counters 0.
  - Memory contents are not reset.
- busy=1 in WAIT_L, CAP_L, WAIT_R and CAP_R. buffer_ready=1 only in READY. Both are registered and follow the state one cycle after the transition edge.
- Read latency: image_data updates the cycle after rd_en, returning mem[image_sel][rd_ptr] at the pre-increment pointer. It holds its value when rd_en=0.
- The first byte after entering READY, or after an image_sel change, is address 0.
- Memory write: one cycle after the qualifying pixel.
- Edge detection on cam_vref and cam_href uses one registered delay. Edges are therefore seen one cycle after the input transition.
- capture in READY drops buffer_ready on the next cycle.
- Reset mid-capture: asynchronous return to IDLE. buffer_ready stays 0 until a full left+right capture completes.

## Structure
- Shared package, holding:
  - WIDTH, HEIGHT, SCALE, and derived LOG2_SCALE, FRAME_PIXELS, ADDR_W.
  - The capture state encoding, shared with the disparity FSM.
- Sub-module frame_ram: two banks of FRAME_PIXELS×8.
  - One synchronous write port: bank select, address, data.
  - One synchronous read port: bank select, address, with 1-cycle latency.
  - Maps to block RAM.
- Top level holds the FSM, edge detectors, counters, address generator and read pointer.

## Test plan
- Full capture, SCALE=16: left frame pixel = (x/16 + y/16) & 0xFF, right frame = 0x80 ^ that, each 736×480. After the right vref rise, buffer_ready=1. Reading with image_sel=0 at address 47 returns 0x02; image_sel=1 at address 47 returns 0x82.
- Camera line of 800 pixels: pixels with x≥736 produce no writes. Address 45 holds the value of pixel x=720 and address 46 is untouched.
- Read wrap and select change: 1380 rd_en reads return addresses 0..1379, then 0 again. Toggling image_sel with rd_en in the same cycle gives a next read of address 0 of the new bank.
- capture pulse during CAP_L is ignored. capture in READY gives buffer_ready=0 next cycle and cam_sel=0.
- Reset asserted mid-CAP_R: buffer_ready=0, busy=0 and cam_sel=0 immediately. A new capture is needed for ready.
- rd_en in WAIT_L does not change image_data and does not advance rd_ptr.
